// File: rtl/boot_sequencer_if.sv
// Register-bus write port used by the boot sequencer to program the SoC boot address.
// The sequencer is the master; the SoC control register block is the slave.
interface boot_sequencer_if;
  logic        reg_req;
  logic [31:0] reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_ack;
  logic        reg_err;

  modport master (
    output reg_req,
    output reg_addr,
    output reg_wdata,
    input  reg_ack,
    input  reg_err
  );

  modport slave (
    input  reg_req,
    input  reg_addr,
    input  reg_wdata,
    output reg_ack,
    output reg_err
  );
endinterface

// File: rtl/boot_sequencer.sv
// Boot sequencer: holds the core in reset, writes the boot address over the register bus,
// optionally waits for an external loader, then enables fetch and watches end-of-computation.
module boot_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter logic [31:0] BOOT_REG_ADDR = 32'h1A10_7008,
  parameter logic [31:0] BOOT_ADDR     = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT   = 255,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ext_load_i,
  input  logic                     load_done_i,
  input  logic                     eoc_i,
  input  logic                     abort_i,
  output logic                     core_rst_n_o,
  boot_sequencer_if.master         bus,
  output logic                     fetch_enable_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     error_o,
  output logic [2:0]               state_o
);

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    CFG       = 3'd1,
    WAIT_LOAD = 3'd2,
    RUN       = 3'd3,
    DONE      = 3'd4,
    ERROR     = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              core_rst_n_q, core_rst_n_d;
  logic              req_q, req_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              fetch_en_q, fetch_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HOLD;
      cnt_q        <= '0;
      core_rst_n_q <= 1'b0;
      req_q        <= 1'b0;
      addr_q       <= 32'h0000_0000;
      wdata_q      <= 32'h0000_0000;
      fetch_en_q   <= 1'b0;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_rst_n_q <= core_rst_n_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      fetch_en_q   <= fetch_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  // Next-state and next-output logic; abort overrides every other event.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    core_rst_n_d = core_rst_n_q;
    req_d        = req_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    fetch_en_d   = fetch_en_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;

    if (abort_i) begin
      state_d      = HOLD;
      cnt_d        = '0;
      core_rst_n_d = 1'b0;
      req_d        = 1'b0;
      fetch_en_d   = 1'b0;
      busy_d       = 1'b1;
      done_d       = 1'b0;
      error_d      = 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == RST_LAST) begin
            state_d      = CFG;
            cnt_d        = '0;
            core_rst_n_d = 1'b1;
            req_d        = 1'b1;
            addr_d       = BOOT_REG_ADDR;
            wdata_d      = BOOT_ADDR;
          end else begin
            cnt_d        = cnt_q + CNT_W'(1);
            core_rst_n_d = 1'b0;
          end
        end
        CFG: begin
          // An ack arriving on the timeout cycle still completes the write.
          if (bus.reg_ack) begin
            req_d = 1'b0;
            cnt_d = '0;
            if (bus.reg_err) begin
              state_d = ERROR;
              error_d = 1'b1;
              busy_d  = 1'b0;
            end else if (ext_load_i) begin
              state_d = WAIT_LOAD;
            end else begin
              state_d    = RUN;
              fetch_en_d = 1'b1;
            end
          end else if (cnt_q == ACK_LAST) begin
            state_d = ERROR;
            req_d   = 1'b0;
            cnt_d   = '0;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        WAIT_LOAD: begin
          if (load_done_i) begin
            state_d    = RUN;
            fetch_en_d = 1'b1;
          end else begin
            state_d = WAIT_LOAD;
          end
        end
        RUN: begin
          if (eoc_i) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = RUN;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        ERROR: begin
          state_d    = ERROR;
          fetch_en_d = 1'b0;
          busy_d     = 1'b0;
        end
        default: begin
          state_d = ERROR;
          error_d = 1'b1;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign core_rst_n_o   = core_rst_n_q;
  assign bus.reg_req    = req_q;
  assign bus.reg_addr   = addr_q;
  assign bus.reg_wdata  = wdata_q;
  assign fetch_enable_o = fetch_en_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign state_o        = state_q;

endmodule
